// File: rtl/sr_ff_pkg.sv
// Shared constants for the SR flip-flop bank: S=R=1 action codes and error counter width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sr_ff_pkg;

    // Action taken when a bit sees s=1 and r=1 on the same edge
    localparam int SR11_HOLD = 0;
    localparam int SR11_SET  = 1;
    localparam int SR11_RST  = 2;
    localparam int SR11_TOG  = 3;

    // Width of the saturating illegal-cycle counter
    localparam int ERR_CNT_W = 8;

    // Any mode code outside the defined set behaves as hold
    function automatic int sr11_norm(input int mode);
        return (mode >= SR11_HOLD && mode <= SR11_TOG) ? mode : SR11_HOLD;
    endfunction

endpackage

// File: rtl/sr_ff_bit.sv
// One SR storage bit with registered true/complement outputs and S=R=1 mode decode.
// Latency: 1 cycle from i_s/i_r to o_q/o_q_b; no combinational input-to-output path.
// Backpressure: none; the bit accepts new set/reset requests every cycle.
//
// Ports:
//   i_clk  rising-edge clock
//   i_rst  synchronous reset, active-high; loads INIT / ~INIT
//   i_s    set request
//   i_r    reset request
//   o_q    stored state
//   o_q_b  complement of o_q, registered alongside it
module sr_ff_bit
    import sr_ff_pkg::*;
#(
    parameter logic INIT      = 1'b0,
    parameter int   SR11_MODE = SR11_HOLD
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_s,
    input  logic i_r,
    output logic o_q,
    output logic o_q_b
);

    localparam int MODE = sr11_norm(SR11_MODE);

    logic r_q;
    logic r_q_b;
    logic w_q_nxt;

    always_comb begin
        w_q_nxt = r_q;
        case ({i_s, i_r})
            2'b10:   w_q_nxt = 1'b1;
            2'b01:   w_q_nxt = 1'b0;
            2'b11: begin
                case (MODE)
                    SR11_SET: w_q_nxt = 1'b1;
                    SR11_RST: w_q_nxt = 1'b0;
                    SR11_TOG: w_q_nxt = ~r_q;
                    default:  w_q_nxt = r_q;
                endcase
            end
            default: w_q_nxt = r_q;
        endcase
    end

    // Complement is its own flop so q_b never glitches relative to q
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q   <= INIT;
            r_q_b <= ~INIT;
        end else begin
            r_q   <= w_q_nxt;
            r_q_b <= ~w_q_nxt;
        end
    end

    assign o_q   = r_q;
    assign o_q_b = r_q_b;

endmodule

// File: rtl/sr_flip_flop.sv
// Bank of WIDTH independent clocked SR bits with true/complement outputs and an illegal-input flag.
// Latency: 1 cycle from s/r to q, q_b and err; no combinational input-to-output path.
// Backpressure: none; s/r are sampled on every rising clk.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous reset, active-high; overrides s/r
//   s, r        per-bit set / reset requests (WIDTH)
//   q, q_b      registered state and its complement (WIDTH)
//   err         one-cycle pulse: some bit saw s=r=1 on the previous edge
//   err_sticky  (SR_FF_STICKY_ERR_EN only) high from first illegal cycle until rst
//   err_cnt     (SR_FF_STICKY_ERR_EN only) illegal-cycle count, saturating at 255
// Build option: define SR_FF_STICKY_ERR_EN to add err_sticky and err_cnt.
module sr_flip_flop
    import sr_ff_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] INIT      = '0,
    parameter int               SR11_MODE = SR11_HOLD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     s,
    input  logic [WIDTH-1:0]     r,
    output logic [WIDTH-1:0]     q,
    output logic [WIDTH-1:0]     q_b,
`ifdef SR_FF_STICKY_ERR_EN
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_cnt,
`endif
    output logic                 err
);

    logic w_illegal;
    logic r_err;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sr_ff_bit #(
            .INIT      (INIT[i]),
            .SR11_MODE (SR11_MODE)
        ) u_bit (
            .i_clk (clk),
            .i_rst (rst),
            .i_s   (s[i]),
            .i_r   (r[i]),
            .o_q   (q[i]),
            .o_q_b (q_b[i])
        );
    end

    // Any number of simultaneously illegal bits collapses to a single flag
    assign w_illegal = |(s & r);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_illegal;
        end
    end

    assign err = r_err;

`ifdef SR_FF_STICKY_ERR_EN
    logic                 r_err_sticky;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_sticky <= 1'b0;
            r_err_cnt    <= '0;
        end else if (w_illegal) begin
            r_err_sticky <= 1'b1;
            // Saturate rather than wrap so a large count is never mistaken for a small one
            if (r_err_cnt != '1) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign err_sticky = r_err_sticky;
    assign err_cnt    = r_err_cnt;
`endif

endmodule

// File: tb/tb_sr_flip_flop.sv
// Self-checking bench for sr_flip_flop: five 4-bit banks (modes 0,1,2,3 and out-of-range 7)
// plus one 1-bit bank, all driven from shared s/r/rst and compared against a behavioural model.
// Build option SR_FF_STICKY_ERR_EN adds err_sticky/err_cnt checks.
module tb_sr_flip_flop;

    localparam int         NK          = 5;
    localparam int         MODES [NK]  = '{0, 1, 2, 3, 7};
    localparam logic [3:0] INITS [NK]  = '{4'h0, 4'hF, 4'h5, 4'hA, 4'h3};

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] s;
    logic [3:0] r;

    logic [3:0] q_o   [NK];
    logic [3:0] qb_o  [NK];
    logic       err_o [NK];
    logic       q1, qb1, err1;
`ifdef SR_FF_STICKY_ERR_EN
    logic       stk_o [NK];
    logic [7:0] cnt_o [NK];
    logic       stk1;
    logic [7:0] cnt1;
`endif

    int checks = 0;
    int errors = 0;

    // reference state
    logic [3:0] m_q [NK];
    logic       m_q1;
    logic       m_err4, m_err1;
    logic       m_stk4, m_stk1;
    int         m_cnt4, m_cnt1;

    always #5 clk = ~clk;

    for (genvar k = 0; k < NK; k++) begin : g_dut
        sr_flip_flop #(
            .WIDTH     (4),
            .INIT      (INITS[k]),
            .SR11_MODE (MODES[k])
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .s          (s),
            .r          (r),
            .q          (q_o[k]),
            .q_b        (qb_o[k]),
`ifdef SR_FF_STICKY_ERR_EN
            .err_sticky (stk_o[k]),
            .err_cnt    (cnt_o[k]),
`endif
            .err        (err_o[k])
        );
    end

    sr_flip_flop #(
        .WIDTH     (1),
        .INIT      (1'b1),
        .SR11_MODE (0)
    ) u_w1 (
        .clk        (clk),
        .rst        (rst),
        .s          (s[0]),
        .r          (r[0]),
        .q          (q1),
        .q_b        (qb1),
`ifdef SR_FF_STICKY_ERR_EN
        .err_sticky (stk1),
        .err_cnt    (cnt1),
`endif
        .err        (err1)
    );

    // Next value of one bit from the behavioural truth table
    function automatic logic next_bit(input int mode, input logic qv, input logic sv, input logic rv);
        if (sv && !rv)  return 1'b1;
        if (!sv && rv)  return 1'b0;
        if (!sv && !rv) return qv;
        if (mode == 1)  return 1'b1;
        if (mode == 2)  return 1'b0;
        if (mode == 3)  return !qv;
        return qv;
    endfunction

    task automatic model_edge();
        if (rst) begin
            for (int k = 0; k < NK; k++) m_q[k] = INITS[k];
            m_q1   = 1'b1;
            m_err4 = 1'b0;
            m_err1 = 1'b0;
            m_stk4 = 1'b0;
            m_stk1 = 1'b0;
            m_cnt4 = 0;
            m_cnt1 = 0;
        end else begin
            int n_ill;
            n_ill = 0;
            for (int b = 0; b < 4; b++) if (s[b] && r[b]) n_ill++;
            for (int k = 0; k < NK; k++)
                for (int b = 0; b < 4; b++)
                    m_q[k][b] = next_bit(MODES[k], m_q[k][b], s[b], r[b]);
            m_q1   = next_bit(0, m_q1, s[0], r[0]);
            m_err4 = (n_ill > 0);
            m_err1 = s[0] && r[0];
            if (m_err4) begin
                m_stk4 = 1'b1;
                m_cnt4 = (m_cnt4 < 255) ? m_cnt4 + 1 : 255;
            end
            if (m_err1) begin
                m_stk1 = 1'b1;
                m_cnt1 = (m_cnt1 < 255) ? m_cnt1 + 1 : 255;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string step);
        for (int k = 0; k < NK; k++) begin
            chk($sformatf("%s q[%0d]", step, k),   {28'b0, q_o[k]},  {28'b0, m_q[k]});
            chk($sformatf("%s q_b[%0d]", step, k), {28'b0, qb_o[k]}, {28'b0, ~m_q[k]});
            chk($sformatf("%s err[%0d]", step, k), {31'b0, err_o[k]}, {31'b0, m_err4});
`ifdef SR_FF_STICKY_ERR_EN
            chk($sformatf("%s sticky[%0d]", step, k), {31'b0, stk_o[k]}, {31'b0, m_stk4});
            chk($sformatf("%s cnt[%0d]", step, k),    {24'b0, cnt_o[k]}, 32'(m_cnt4));
`endif
        end
        chk($sformatf("%s w1 q", step),   {31'b0, q1},   {31'b0, m_q1});
        chk($sformatf("%s w1 q_b", step), {31'b0, qb1},  {31'b0, ~m_q1});
        chk($sformatf("%s w1 err", step), {31'b0, err1}, {31'b0, m_err1});
`ifdef SR_FF_STICKY_ERR_EN
        chk($sformatf("%s w1 sticky", step), {31'b0, stk1}, {31'b0, m_stk1});
        chk($sformatf("%s w1 cnt", step),    {24'b0, cnt1}, 32'(m_cnt1));
`endif
    endtask

    // Apply inputs away from the edge, let one rising edge happen, then compare
    task automatic drive(input string step, input logic [3:0] sv, input logic [3:0] rv, input logic rstv);
        s   = sv;
        r   = rv;
        rst = rstv;
        @(posedge clk);
        model_edge();
        #1;
        check_all(step);
    endtask

    initial begin
        s   = 4'h0;
        r   = 4'h0;
        rst = 1'b1;
        #2;

        drive("reset",       4'h0, 4'h0, 1'b1);
        drive("set_all",     4'hF, 4'h0, 1'b0);
        drive("hold1",       4'h0, 4'h0, 1'b0);
        drive("hold2",       4'h0, 4'h0, 1'b0);
        drive("hold3",       4'h0, 4'h0, 1'b0);
        drive("clear",       4'h0, 4'hF, 1'b0);
        drive("set",         4'hF, 4'h0, 1'b0);
        drive("sr11",        4'hF, 4'hF, 1'b0);
        drive("err_fall",    4'h0, 4'h0, 1'b0);
        drive("rst_wins",    4'hF, 4'h0, 1'b1);
        drive("load_a",      4'hA, 4'h5, 1'b0);
        drive("mixed",       4'h5, 4'h3, 1'b0);
        drive("ill2",        4'h1, 4'h1, 1'b0);
        drive("ill3",        4'h6, 4'h4, 1'b0);
        drive("quiet",       4'h0, 4'h0, 1'b0);

        for (int i = 0; i < 260; i++) drive("saturate", 4'hF, 4'hF, 1'b0);
        drive("sat_quiet",   4'h0, 4'h0, 1'b0);
        drive("rst_mid",     4'h3, 4'hC, 1'b1);

        for (int i = 0; i < 300; i++) begin
            drive("random", 4'($urandom), 4'($urandom), ($urandom_range(0, 19) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
